// File: rtl/seq_comparator_ctrl.sv
// Purpose: compares two W-bit unsigned words one 2-bit slice per clock, MSB pair first.
// Latency: done pulses n clocks after start is accepted (n = slices evaluated, 1..W/2).
// Backpressure: start is only sampled in IDLE; requests during RUN/DONE are dropped, not queued.
module seq_comparator_ctrl #(
   parameter int W          = 8,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int N         = W / 2,
   localparam int CW        = $clog2(W / 2) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   output logic          busy,
   output logic          done,
   output logic          f1,
   output logic          f2,
   output logic          f3,
   output logic [CW-1:0] cycles
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_K = CW'(N);

   state_t          state_q;
   // Operands are shifted left by one pair per RUN clock, so the slice
   // under evaluation is always the top two bits.
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [CW-1:0]   cnt_q;
   // First unequal slice seen so far (only consulted when EARLY_EXIT=0).
   logic            rec_vld_q;
   logic            rec_gt_q;
   logic            busy_q;
   logic            done_q;
   logic            f1_q;
   logic            f2_q;
   logic            f3_q;
   logic [CW-1:0]   cycles_q;

   logic [1:0]      pair_a_d;
   logic [1:0]      pair_b_d;
   logic            pair_gt_d;
   logic            pair_lt_d;
   logic            pair_ne_d;
   logic [CW-1:0]   k_d;
   logic            last_d;
   logic            res_gt_d;
   logic            res_lt_d;

   // Comparator slice plus final-result selection for the last slice.
   always_comb begin
      pair_a_d  = a_q[W-1 -: 2];
      pair_b_d  = b_q[W-1 -: 2];
      pair_gt_d = (pair_a_d > pair_b_d);
      pair_lt_d = (pair_a_d < pair_b_d);
      pair_ne_d = pair_gt_d | pair_lt_d;
      k_d       = cnt_q + CW'(1);
      last_d    = (k_d == LAST_K);
      res_gt_d  = 1'b0;
      res_lt_d  = 1'b0;
      if (rec_vld_q) begin
         res_gt_d = rec_gt_q;
         res_lt_d = ~rec_gt_q;
      end else begin
         res_gt_d = pair_gt_d;
         res_lt_d = pair_lt_d;
      end
   end

   // Sequencing FSM with all outputs registered; reset aborts any job in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         rec_vld_q <= 1'b0;
         rec_gt_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         f1_q      <= 1'b0;
         f2_q      <= 1'b0;
         f3_q      <= 1'b0;
         cycles_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q       <= a;
                  b_q       <= b;
                  cnt_q     <= '0;
                  rec_vld_q <= 1'b0;
                  rec_gt_q  <= 1'b0;
                  f1_q      <= 1'b0;
                  f2_q      <= 1'b0;
                  f3_q      <= 1'b0;
                  cycles_q  <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= S_RUN;
               end
            end
            S_RUN: begin
               a_q   <= a_q << 2;
               b_q   <= b_q << 2;
               cnt_q <= k_d;
               if (EARLY_EXIT && pair_ne_d) begin
                  f1_q     <= pair_gt_d;
                  f2_q     <= 1'b0;
                  f3_q     <= pair_lt_d;
                  cycles_q <= k_d;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else if (last_d) begin
                  f1_q     <= res_gt_d;
                  f2_q     <= ~(res_gt_d | res_lt_d);
                  f3_q     <= res_lt_d;
                  cycles_q <= k_d;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end else if (pair_ne_d && !rec_vld_q) begin
                  rec_vld_q <= 1'b1;
                  rec_gt_q  <= pair_gt_d;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign f1     = f1_q;
   assign f2     = f2_q;
   assign f3     = f3_q;
   assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_comparator_ctrl.sv
// Directed bench for seq_comparator_ctrl: one early-exit instance and one full-scan instance.
// Outputs are sampled 1 time unit after each rising edge.
// Every wait on done is bounded by a cycle budget.
module tb_seq_comparator_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start0;
   logic [7:0] a;
   logic [7:0] b;

   logic       busy, done, f1, f2, f3;
   logic [2:0] cycles;
   logic       busy0, done0, f10, f20, f30;
   logic [2:0] cycles0;

   int tests = 0;
   int fails = 0;
   int n;
   int done_cnt;

   always #5 clk = ~clk;

   seq_comparator_ctrl #(.W(8), .EARLY_EXIT(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .f1(f1), .f2(f2), .f3(f3), .cycles(cycles)
   );

   seq_comparator_ctrl #(.W(8), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .a(a), .b(b),
      .busy(busy0), .done(done0), .f1(f10), .f2(f20), .f3(f30), .cycles(cycles0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] flags(input bit sel);
      return sel ? {f10, f20, f30} : {f1, f2, f3};
   endfunction

   function automatic logic done_of(input bit sel);
      return sel ? done0 : done;
   endfunction

   // Counts edges after the accepting edge until done is seen (bounded).
   task automatic wait_done(input bit sel, input string tag, output int edges);
      edges = 0;
      do begin
         tick();
         edges++;
      end while (!done_of(sel) && edges < 20);
      chk({tag, "_done_seen"}, done_of(sel), 1'b1);
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      start0 = 1'b0;
      a      = 8'h00;
      b      = 8'h00;
      #3;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", flags(0), 3'b000);
      chk("rst_cycles", cycles, 3'd0);
      chk("rst_busy0", busy0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 1'b0);

      // 1: equal operands, all four slices
      a = 8'hA5; b = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t1_busy_run", busy, 1'b1);
      chk("t1_flags_run", flags(0), 3'b000);
      wait_done(0, "t1", n);
      chk("t1_edge", n, 4);
      chk("t1_flags", flags(0), 3'b010);
      chk("t1_cycles", cycles, 3'd4);
      chk("t1_busy_done", busy, 1'b1);
      tick();
      chk("t1_done_pulse", done, 1'b0);
      chk("t1_busy_idle", busy, 1'b0);
      tick();
      chk("t1_flags_hold", flags(0), 3'b010);
      chk("t1_cycles_hold", cycles, 3'd4);

      // 2: MSB slice decides greater
      a = 8'h80; b = 8'h7F; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t2_cycles_clr", cycles, 3'd0);
      chk("t2_flags_clr", flags(0), 3'b000);
      wait_done(0, "t2", n);
      chk("t2_edge", n, 1);
      chk("t2_flags", flags(0), 3'b100);
      chk("t2_cycles", cycles, 3'd1);
      tick();

      // 3: LSB slice decides less
      a = 8'h34; b = 8'h36; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(0, "t3", n);
      chk("t3_edge", n, 4);
      chk("t3_flags", flags(0), 3'b001);
      chk("t3_cycles", cycles, 3'd4);
      tick();

      // 4: start held, operands changed mid-job
      a = 8'h12; b = 8'h11; start = 1'b1;
      tick();
      a = 8'hFF; b = 8'h00;
      wait_done(0, "t4", n);
      chk("t4_edge", n, 4);
      chk("t4_flags", flags(0), 3'b100);
      chk("t4_cycles", cycles, 3'd4);
      tick();
      chk("t4_idle_busy", busy, 1'b0);
      chk("t4_idle_done", done, 1'b0);
      tick();
      start = 1'b0;
      chk("t4_reaccept_busy", busy, 1'b1);
      chk("t4_reaccept_flags", flags(0), 3'b000);
      tick();
      chk("t4_second_done", done, 1'b1);
      chk("t4_second_flags", flags(0), 3'b100);
      chk("t4_second_cycles", cycles, 3'd1);
      tick();

      // 5: reset mid-RUN aborts the job
      a = 8'h55; b = 8'h55; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("t5_rst_busy", busy, 1'b0);
      chk("t5_rst_done", done, 1'b0);
      chk("t5_rst_flags", flags(0), 3'b000);
      chk("t5_rst_cycles", cycles, 3'd0);
      tick();
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done || busy) done_cnt++;
      end
      chk("t5_no_done", done_cnt, 0);
      a = 8'h01; b = 8'h02; start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(0, "t5", n);
      chk("t5_edge", n, 4);
      chk("t5_flags", flags(0), 3'b001);
      tick();

      // 6: full-scan instance
      a = 8'hC0; b = 8'h00; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(1, "t6", n);
      chk("t6_edge", n, 4);
      chk("t6_flags", flags(1), 3'b100);
      chk("t6_cycles", cycles0, 3'd4);
      chk("t6_other_idle", busy, 1'b0);
      tick();
      chk("t6_busy_idle", busy0, 1'b0);

      // 6b: full scan keeps the first unequal slice, not a later one
      a = 8'h4F; b = 8'h30; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(1, "t6b", n);
      chk("t6b_edge", n, 4);
      chk("t6b_flags", flags(1), 3'b100);

      // 6c: full scan, equal operands
      tick();
      a = 8'h3C; b = 8'h3C; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_done(1, "t6c", n);
      chk("t6c_edge", n, 4);
      chk("t6c_flags", flags(1), 3'b010);
      chk("t6c_cycles", cycles0, 3'd4);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
